// File: rtl/pe_interco_pkg.sv
// Shared types and helpers for the peripheral interconnect request/response paths.
package pe_interco_pkg;

    localparam int PE_DATA_WIDTH = 32;
    localparam int PE_ID_WIDTH   = 17;

    // The collector's DATA_WIDTH and ID_WIDTH are expected to match these widths.
    typedef struct packed {
        logic [PE_DATA_WIDTH-1:0] rdata;
        logic                     opc;
    } pe_resp_t;

    function automatic logic onehot_match(input logic [PE_ID_WIDTH-1:0] id,
                                          input logic [PE_ID_WIDTH-1:0] mask);
        return |(id & mask);
    endfunction

endpackage

// File: rtl/pe_rr_arb.sv
// Round-robin arbiter: the first request at or after ptr+1 wins; ptr moves to the winner on any request.
module pe_rr_arb #(
    parameter int N     = 16,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves a latch behind.
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    assign ptr_d = (|req_i) ? idx_o : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            ptr_q <= IDX_W'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pe_resp_collector.sv
// Per-master response collector: ID filter, round-robin arbitration across slaves,
// registered response toward the master and outstanding-request accounting.
module pe_resp_collector
    import pe_interco_pkg::*;
#(
    parameter int                ID_WIDTH        = 17,
    parameter logic [ID_WIDTH-1:0] ID            = ID_WIDTH'(1),
    parameter int                N_SLAVE         = 16,
    parameter int                DATA_WIDTH      = 32,
    parameter int                MAX_OUTSTANDING = 4,
    parameter int                CNT_W           = $clog2(MAX_OUTSTANDING + 1),
    parameter int                IDX_W           = $clog2(N_SLAVE)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_fire_i,
    output logic                                 req_block_o,
    input  logic [N_SLAVE-1:0]                   r_valid_i,
    input  logic [N_SLAVE-1:0][ID_WIDTH-1:0]     r_ID_i,
    input  logic [N_SLAVE-1:0][DATA_WIDTH-1:0]   r_rdata_i,
    input  logic [N_SLAVE-1:0]                   r_opc_i,
    output logic [N_SLAVE-1:0]                   r_stall_o,
    output logic                                 r_valid_o,
    output logic [DATA_WIDTH-1:0]                r_rdata_o,
    output logic                                 r_opc_o,
    output logic [CNT_W-1:0]                     outstanding_o,
    output logic                                 idle_o,
    output logic                                 err_unexpected_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [N_SLAVE-1:0] match;
    logic [N_SLAVE-1:0] gnt;
    logic [IDX_W-1:0]   win_idx;
    logic               any_match;

    logic               r_valid_q, r_valid_d;
    pe_resp_t           resp_q, resp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               inc, dec;

    always_comb begin
        match = '0;
        for (int s = 0; s < N_SLAVE; s++) begin
            match[s] = r_valid_i[s] && onehot_match(r_ID_i[s], ID);
        end
    end

    assign any_match = |match;

    pe_rr_arb #(
        .N     (N_SLAVE),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (match),
        .gnt_o (gnt),
        .idx_o (win_idx)
    );

    // Losers must hold their response; the winner is consumed this cycle.
    assign r_stall_o = match & ~gnt;

    always_comb begin
        r_valid_d = any_match;
        resp_d    = resp_q;
        if (any_match) begin
            resp_d.rdata = r_rdata_i[win_idx];
            resp_d.opc   = r_opc_i[win_idx];
        end
    end

    assign inc = req_fire_i;
    assign dec = r_valid_q;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q | (dec && (cnt_q == '0));
        unique case ({inc, dec})
            2'b10:   if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            2'b01:   if (cnt_q != '0)      cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q <= 1'b0;
            resp_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            r_valid_q <= r_valid_d;
            resp_q    <= resp_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign r_valid_o        = r_valid_q;
    assign r_rdata_o        = resp_q.rdata;
    assign r_opc_o          = resp_q.opc;
    assign outstanding_o    = cnt_q;
    assign err_unexpected_o = err_q;
    assign idle_o           = (cnt_q == '0) && !r_valid_q;
    // A response draining this cycle frees a slot for a same-cycle request.
    assign req_block_o      = (cnt_q == CNT_MAX) && !r_valid_q;

endmodule
